// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the floating-point multiplier family.
// - round_values : rounding mode selector, also imported by exception_mult
//                  and by the future adder/divider blocks.
// - state_t      : sequencing states of fp_mult_core.
// - BIAS, EXP_MAX, MANT_W : single-precision format constants.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IEEE_near,
    IEEE_zero,
    IEEE_pinf,
    IEEE_ninf,
    near_up,
    away_zero
  } round_values;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ROUND,
    DONE
  } state_t;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 254;
  localparam int MANT_W  = 23;

endpackage

// File: rtl/fp_round.sv
// Rounding decision shared by the floating-point datapaths.
// Ports:
//   mode_i  rounding mode (round_values encoding)
//   sign_i  sign of the result
//   l_i     least significant kept mantissa bit
//   g_i     guard bit (first discarded bit)
//   s_i     sticky bit (OR of all lower discarded bits)
//   up_o    1 when the kept mantissa must be incremented
module fp_round
  import fp_mult_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic       sign_i,
  input  logic       l_i,
  input  logic       g_i,
  input  logic       s_i,
  output logic       up_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives up_o;
    // otherwise an unlisted mode would infer a latch.
    up_o = 1'b0;
    case (mode_i)
      IEEE_near: up_o = g_i & (s_i | l_i);   // ties go to even
      IEEE_zero: up_o = 1'b0;                // truncate
      IEEE_pinf: up_o = (g_i | s_i) & ~sign_i;
      IEEE_ninf: up_o = (g_i | s_i) & sign_i;
      near_up:   up_o = g_i & (s_i | ~sign_i); // ties toward +inf
      away_zero: up_o = g_i | s_i;
      default:   up_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_mult_core.sv
// Sequential single-precision multiplier datapath. Produces the raw packed
// result and overflow/underflow/inexact indications; special operands are
// not classified here (exception_mult downstream overrides them).
// A radix-2 shift-add significand multiplier runs for 24 cycles, followed by
// one normalize/round cycle, then the result is held until taken.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   a, b                operands
//   out_valid/out_ready result handshake
//   z_calc              {sign, exp[7:0], mantissa[22:0]}
//   overflow, underflow final biased exponent > 254 / < 1 (signed)
//   inexact             guard or sticky nonzero
module fp_mult_core
  import fp_mult_pkg::*;
#(
  parameter round_values round = IEEE_near
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z_calc,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;        // signed biased exponent with headroom
  logic [23:0] ma_q, ma_d;
  logic [23:0] mb_q, mb_d;
  logic [47:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] z_q, z_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inx_q, inx_d;

  // Normalize / round datapath, evaluated from the finished product.
  logic              norm;
  logic [MANT_W-1:0] mant_pre;
  logic              g_bit;
  logic              s_bit;
  logic              up;
  logic [9:0]        exp_norm;
  logic [MANT_W:0]   mant_inc;
  logic [9:0]        exp_fin;
  logic              ovf_fin;
  logic              unf_fin;

  assign norm     = prod_q[47];   // product in [2,4): shift one more place
  assign mant_pre = norm ? prod_q[46:24] : prod_q[45:23];
  assign g_bit    = norm ? prod_q[23] : prod_q[22];
  assign s_bit    = norm ? (|prod_q[22:0]) : (|prod_q[21:0]);
  assign exp_norm = exp_q + {9'b0, norm};

  fp_round u_round (
    .mode_i (round),
    .sign_i (sign_q),
    .l_i    (mant_pre[0]),
    .g_i    (g_bit),
    .s_i    (s_bit),
    .up_o   (up)
  );

  // A carry out of the increment leaves the low bits all zero, which is the
  // correct mantissa field for the bumped exponent.
  assign mant_inc = {1'b0, mant_pre} + {{MANT_W{1'b0}}, up};
  assign exp_fin  = exp_norm + {9'b0, mant_inc[MANT_W]};
  assign ovf_fin  = $signed(exp_fin) > $signed(10'(EXP_MAX));
  assign unf_fin  = $signed(exp_fin) < $signed(10'd1);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a[31] ^ b[31];
          exp_d   = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'(BIAS);
          ma_d    = {1'b1, a[22:0]};
          mb_d    = {1'b1, b[22:0]};
          prod_d  = '0;   // accumulator starts clean for every operation
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mb_q[cnt_q]) begin
          prod_d = prod_q + ({24'b0, ma_q} << cnt_q);
        end
        if (cnt_q == 5'd23) begin
          cnt_d   = '0;
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ROUND: begin
        z_d     = {sign_q, exp_fin[7:0], mant_inc[MANT_W-1:0]};
        ovf_d   = ovf_fin;
        unf_d   = unf_fin;
        inx_d   = g_bit | s_bit;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z_calc    = z_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_mult_core.sv
// Self-checking bench for fp_mult_core. Two instances (round-to-nearest-even
// and round-toward-+inf) share the same stimulus; results are compared with
// an arithmetic reference model built from integer multiplication.
module tb_fp_mult_core;
  import fp_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic        in_ready_n, out_valid_n, ovf_n, unf_n, inx_n;
  logic [31:0] z_n;
  logic        in_ready_p, out_valid_p, ovf_p, unf_p, inx_p;
  logic [31:0] z_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mult_core #(.round(IEEE_near)) dut_near (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .a(a), .b(b), .out_valid(out_valid_n), .out_ready(out_ready),
    .z_calc(z_n), .overflow(ovf_n), .underflow(unf_n), .inexact(inx_n)
  );

  fp_mult_core #(.round(IEEE_pinf)) dut_pinf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p),
    .a(a), .b(b), .out_valid(out_valid_p), .out_ready(out_ready),
    .z_calc(z_p), .overflow(ovf_p), .underflow(unf_p), .inexact(inx_p)
  );

  typedef struct {
    logic [31:0] z;
    logic        ovf;
    logic        unf;
    logic        inx;
  } res_t;

  // Reference: exact integer product of the significands, then round the
  // discarded remainder against half an ulp.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input round_values m);
    res_t r;
    longint unsigned mx, my, p, mant, rem, half, ulp;
    int e, sh;
    bit sgn, up;
    logic [31:0] ev;
    sgn  = x[31] ^ y[31];
    mx   = 64'(x[22:0]) + (64'd1 << 23);
    my   = 64'(y[22:0]) + (64'd1 << 23);
    p    = mx * my;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e = e + 1;
    ulp  = 64'd1 << sh;
    mant = p / ulp;
    rem  = p % ulp;
    half = ulp / 2;
    case (m)
      IEEE_near: up = (rem > half) || (rem == half && (mant % 2) == 1);
      IEEE_zero: up = 1'b0;
      IEEE_pinf: up = (rem != 0) && !sgn;
      IEEE_ninf: up = (rem != 0) && sgn;
      near_up:   up = (rem > half) || (rem == half && !sgn);
      default:   up = (rem != 0);
    endcase
    mant = mant + (up ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) e = e + 1;
    ev    = e;
    r.z   = {sgn, ev[7:0], mant[22:0]};
    r.ovf = (e > 254);
    r.unf = (e < 1);
    r.inx = (rem != 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] ta,
                               input logic [31:0] tb_v);
    res_t rn, rp;
    rn = model(ta, tb_v, IEEE_near);
    rp = model(ta, tb_v, IEEE_pinf);
    check({tag, "_z_near"},   z_n,          rn.z);
    check({tag, "_ovf_near"}, 32'(ovf_n),   32'(rn.ovf));
    check({tag, "_unf_near"}, 32'(unf_n),   32'(rn.unf));
    check({tag, "_inx_near"}, 32'(inx_n),   32'(rn.inx));
    check({tag, "_z_pinf"},   z_p,          rp.z);
    check({tag, "_ovf_pinf"}, 32'(ovf_p),   32'(rp.ovf));
    check({tag, "_unf_pinf"}, 32'(unf_p),   32'(rp.unf));
    check({tag, "_inx_pinf"}, 32'(inx_p),   32'(rp.inx));
  endtask

  // Presents operands and returns 1 ns after the accepting edge.
  task automatic start(input logic [31:0] ta, input logic [31:0] tb_v);
    int k;
    @(negedge clk);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready_n && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(in_ready_n), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  // Counts rising edges, the accepting edge being the first, until out_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid_n && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ta,
                     input logic [31:0] tb_v);
    int lat;
    start(ta, tb_v);
    wait_result(lat);
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check({tag, "_valid_pinf"}, 32'(out_valid_p), 32'd1);
    check_outputs(tag, ta, tb_v);
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, 32'(out_valid_n), 32'd0);
  endtask

  initial begin
    int lat;
    res_t held;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #13;
    check("rst_in_ready",  32'(in_ready_n),  32'd1);
    check("rst_out_valid", 32'(out_valid_n), 32'd0);
    check("rst_z",         z_n,              32'd0);
    check("rst_flags",     {29'b0, ovf_n, unf_n, inx_n}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors.
    run("one_x_two", 32'h3F800000, 32'h40000000);
    check("tp_one_x_two_z", z_n, 32'h40000000);
    run("norm_path", 32'h3FC00000, 32'h3FC00000);
    check("tp_norm_path_z", z_n, 32'h40100000);
    run("round_lsb", 32'h3F800001, 32'h3F800001);
    check("tp_round_near_z", z_n, 32'h3F800002);
    check("tp_round_near_inx", 32'(inx_n), 32'd1);
    check("tp_round_pinf_z", z_p, 32'h3F800003);
    run("overflow", 32'h7F000000, 32'h40000000);
    check("tp_overflow", {30'b0, ovf_n, unf_n}, 32'd2);
    run("underflow", 32'h00800000, 32'h3F000000);
    check("tp_underflow", {30'b0, ovf_n, unf_n}, 32'd1);
    run("neg_carry", 32'hBFFFFFFF, 32'h3FFFFFFF);

    // Backpressure: result must hold and no operand may be taken.
    out_ready = 1'b0;
    start(32'h3FC00000, 32'h3FC00000);
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd26);
    held = model(32'h3FC00000, 32'h3FC00000, IEEE_near);
    a = 32'h40000000;
    b = 32'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid_n), 32'd1);
      check("bp_in_ready",  32'(in_ready_n),  32'd0);
      check("bp_z",         z_n,              held.z);
      check("bp_flags", {29'b0, ovf_n, unf_n, inx_n},
            {29'b0, held.ovf, held.unf, held.inx});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid_n), 32'd0);
    check("bp_release_ready", 32'(in_ready_n),  32'd1);
    @(posedge clk);
    #1;
    check("bp_single_accept", 32'(in_ready_n), 32'd0);
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_next_latency", 32'(lat), 32'd26);
    check_outputs("bp_next", 32'h40000000, 32'h40000000);
    @(posedge clk);
    #1;
    check("bp_next_idle", 32'(in_ready_n), 32'd1);

    // Asynchronous reset in the middle of the multiply.
    start(32'h3FC00000, 32'h40400000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid_n), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready_n),  32'd1);
    check("mid_rst_z",         z_n,              32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("after_rst", 32'h3F800000, 32'h3F800000);
    check("tp_after_rst_z", z_n, 32'h3F800000);

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      run("rand", $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mult_core.md
Name: fp_mult_core

Overview:
- Sequential IEEE-754 single-precision multiplier datapath. It produces the raw result and the overflow, underflow and inexact indications consumed by exception_mult, which is instantiated downstream.
- Uses a radix-2 shift-add significand multiplier, then one normalize/round cycle.
- Valid/ready handshake on both sides. Never classifies special operands (zero/inf/NaN/denorm); exception_mult overrides those.

Parameters:
- round, IEEE_near, rounding mode of type round_values (IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero); must match exception_mult's round.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands a/b valid
- in_ready  output  1  core can accept operands
- a  input  32  operand A
- b  input  32  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- z_calc  output  32  {sign, exp[7:0], mantissa[22:0]} before exception handling
- overflow  output  1  final biased exponent > 254
- underflow  output  1  final biased exponent < 1
- inexact  output  1  guard or sticky nonzero

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0.
  - z_calc=0; overflow=0; underflow=0; inexact=0; counter and accumulators cleared.
- Reset mid-operation aborts silently; no result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register the following, then go to MUL:
    - sign = a[31]^b[31]
    - exp = {2'b0,a[30:23]} + {2'b0,b[30:23]} - 127, as 10-bit signed
    - ma = {1,a[22:0]}, mb = {1,b[22:0]}; hidden bit is always 1
  - MUL: 24 cycles, 5-bit counter 0..23. Each cycle, if mb bit[counter] is set, add ma<<counter into the 48-bit product. At counter==23 go to ROUND. in_ready=0.
  - ROUND: one cycle.
    - If P[47]: mant=P[46:24], G=P[23], S=|P[22:0], exp+=1.
    - Else: mant=P[45:23], G=P[22], S=|P[21:0].
    - up decision, with L = mant[0]:
      - IEEE_near: G&(S|L)
      - IEEE_zero: 0
      - IEEE_pinf: (G|S)&~sign
      - IEEE_ninf: (G|S)&sign
      - near_up: G&(S|~sign)
      - away_zero: G|S
    - mant+up carry-out: mant=0, exp+=1.
    - Register z_calc={sign,exp[7:0],mant}, overflow=(exp>254), underflow=(exp<1), inexact=G|S.
    - Go to DONE.
  - DONE: out_valid=1; outputs held stable while out_ready=0. On out_ready go to IDLE; out_valid drops on that edge.
- Latency: out_valid rises exactly 26 rising edges after the accepting edge. Throughput is 1 result per 27 cycles minimum.
- in_ready=1 only in IDLE; no operand is accepted while busy or holding a result.
- Overflow and underflow are evaluated after rounding. Both are signed compares on the 10-bit exp and are mutually exclusive.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- fp_mult_pkg holds:
  - round_values typedef, moved out of global scope; exception_mult imports it
  - state enum {IDLE, MUL, ROUND, DONE}
  - constants BIAS=127, EXP_MAX=254, MANT_W=23
- One combinational sub-module fp_round takes mode, sign, L, G, S and returns up. It is reused by future adder/divider blocks.

Test Plan:
- a=3F800000, b=40000000, out_ready=1 → after 26 cycles z_calc=40000000; overflow=0, underflow=0, inexact=0.
- a=3FC00000, b=3FC00000 → z_calc=40100000, all flags 0. Exercises the P[47] normalize path.
- a=3F800001, b=3F800001:
  - round=IEEE_near → z_calc=3F800002, inexact=1
  - round=IEEE_pinf → z_calc=3F800003
- a=7F000000, b=40000000 → overflow=1, underflow=0. a=00800000, b=3F000000 → underflow=1, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Require z_calc and flags stable, in_ready=0, and no new operand accepted; release → single accept next cycle.
- Drop rst at MUL cycle 10 → out_valid=0 and in_ready=1 immediately (async). The next transaction 3F800000×3F800000 yields 3F800000 with no stale product bits.
